// File: rtl/if_id_queue.sv
// Two-entry fetch-to-decode queue that pairs fetch slots with in-order bus read data.
// Optional idle-cycle counter: define IF_ID_BUBBLE_CNT_EN to add the bubble_cnt output.
module if_id_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_exr_valid,
  input  logic [5:0]  if_exr_type,
  output logic        if_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_exr_valid,
  output logic [5:0]  id_exr_type
`ifdef IF_ID_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  logic [31:0] pc_q [2];
  logic [31:0] pc_d [2];
  logic [31:0] inst_q [2];
  logic [31:0] inst_d [2];
  logic [5:0]  exr_type_q [2];
  logic [5:0]  exr_type_d [2];
  logic [1:0]  exr_valid_q, exr_valid_d;
  logic [1:0]  done_q, done_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  discard_q, discard_d;

  logic        second;
  logic        tail;
  logic        wait0, wait1;
  logic        push, pop;
  logic [2:0]  disc_sum;

  assign second = ~head_q;
  assign tail   = head_q ^ count_q[0];

  // Entries still owed a bus read, in queue order.
  assign wait0 = (count_q != 2'd0) && !exr_valid_q[head_q] && !done_q[head_q];
  assign wait1 = (count_q == 2'd2) && !exr_valid_q[second] && !done_q[second];

  assign if_ready     = (count_q != 2'd2);
  assign id_valid     = (count_q != 2'd0) && (exr_valid_q[head_q] || done_q[head_q]);
  assign id_pc        = pc_q[head_q];
  assign id_inst      = inst_q[head_q];
  assign id_exr_valid = exr_valid_q[head_q];
  assign id_exr_type  = exr_type_q[head_q];

  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    exr_type_d  = exr_type_q;
    exr_valid_d = exr_valid_q;
    done_d      = done_q;
    head_d      = head_q;
    count_d     = count_q;
    discard_d   = discard_q;
    disc_sum    = 3'd0;

    if (flush) begin
      count_d  = 2'd0;
      disc_sum = {1'b0, discard_q} + {2'b00, wait0} + {2'b00, wait1};
      // A return in the flush cycle retires one owed read; it is never delivered.
      if (ibus_rvalid && (disc_sum != 3'd0)) begin
        disc_sum = disc_sum - 3'd1;
      end
      discard_d = (disc_sum > 3'd2) ? 2'd2 : disc_sum[1:0];
    end else begin
      if (ibus_rvalid) begin
        if (discard_q != 2'd0) begin
          discard_d = discard_q - 2'd1;
        end else if (wait0) begin
          inst_d[head_q] = ibus_rdata;
          done_d[head_q] = 1'b1;
        end else if (wait1) begin
          inst_d[second] = ibus_rdata;
          done_d[second] = 1'b1;
        end
      end

      if (pop) begin
        head_d = ~head_q;
      end

      // Push needs a free slot, so it never collides with a data write to the second entry.
      if (push) begin
        pc_d[tail]        = if_pc;
        exr_valid_d[tail] = if_exr_valid;
        exr_type_d[tail]  = if_exr_type;
        done_d[tail]      = 1'b0;
        inst_d[tail]      = 32'h0;
      end

      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= '{default: '0};
      inst_q      <= '{default: '0};
      exr_type_q  <= '{default: '0};
      exr_valid_q <= 2'b00;
      done_q      <= 2'b00;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      discard_q   <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      exr_type_q  <= exr_type_d;
      exr_valid_q <= exr_valid_d;
      done_q      <= done_d;
      head_q      <= head_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= 32'd0;
    end else if (!id_valid) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboarded bench for if_id_queue: a queue-level reference model predicts pops,
// a separate monitor compares each DUT pop against the predicted entry.
module tb_if_id_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        if_exr_valid = 1'b0;
  logic [5:0]  if_exr_type = 6'h0;
  logic        if_ready;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = 32'h0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_exr_valid;
  logic [5:0]  id_exr_type;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clock = ~clock;

  if_id_queue dut (
    .clock        (clock),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_exr_valid (if_exr_valid),
    .if_exr_type  (if_exr_type),
    .if_ready     (if_ready),
    .ibus_rvalid  (ibus_rvalid),
    .ibus_rdata   (ibus_rdata),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_exr_valid (id_exr_valid),
    .id_exr_type  (id_exr_type)
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        exr;
    logic [5:0]  et;
    logic        done;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exr;
    logic [5:0]  et;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   disc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: advances one cycle using the inputs currently applied.
  task automatic model_step();
    bit   mvalid, mready;
    int   w, tot;
    ent_t e;
    mvalid = (mq.size() > 0) && (mq[0].exr || mq[0].done);
    mready = (mq.size() < 2);
    chk("id_valid", 64'(id_valid), 64'(mvalid));
    chk("if_ready", 64'(if_ready), 64'(mready));
    if (flush) begin
      w = 0;
      foreach (mq[k]) if (!mq[k].exr && !mq[k].done) w++;
      tot = disc + w;
      if (ibus_rvalid && tot > 0) tot--;
      disc = (tot > 2) ? 2 : tot;
      mq.delete();
    end else begin
      if (ibus_rvalid) begin
        if (disc > 0) begin
          disc--;
        end else begin
          for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].exr && !mq[k].done) begin
              e = mq[k];
              e.done = 1'b1;
              e.inst = ibus_rdata;
              mq[k] = e;
              break;
            end
          end
        end
      end
      if (mvalid && id_ready) begin
        e = mq.pop_front();
        sb.push_back('{e.pc, e.inst, e.exr, e.et});
      end
      if (if_valid && mready) mq.push_back('{if_pc, if_exr_valid, if_exr_type, 1'b0, 32'h0});
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic ex, input logic [5:0] et,
                      input logic rv, input logic [31:0] rd, input logic fl, input logic rdy);
    if_valid = v; if_pc = pc; if_exr_valid = ex; if_exr_type = et;
    ibus_rvalid = rv; ibus_rdata = rd; flush = fl; id_ready = rdy;
    @(negedge clock);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_id_valid"}, 64'(id_valid), 64'd0);
    chk({tag, "_if_ready"}, 64'(if_ready), 64'd1);
    chk({tag, "_id_pc"}, 64'(id_pc), 64'd0);
    chk({tag, "_id_inst"}, 64'(id_inst), 64'd0);
    chk({tag, "_id_exr"}, {57'd0, id_exr_valid, id_exr_type}, 64'd0);
  endtask

  // Monitor: every DUT pop must match the oldest predicted pop.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      #1;
      if (reset && id_valid && id_ready && !flush) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected actual pc=%0h required=no pop", id_pc);
        end else begin
          x = sb.pop_front();
          chk("pop_pc", 64'(id_pc), 64'(x.pc));
          chk("pop_inst", 64'(id_inst), 64'(x.inst));
          chk("pop_exr", {57'd0, id_exr_valid, id_exr_type}, {57'd0, x.exr, x.et});
        end
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 5; i++) idle(1'b0);
`ifdef IF_ID_BUBBLE_CNT_EN
    chk("bubble_cnt", 64'(bubble_cnt), 64'd5);
`endif

    // Basic fetch: data returned one cycle after push, presented the cycle after.
    step(1'b1, 32'hbfc00000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'h24080001, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to full with decode stalled; third slot refused; drain in order.
    step(1'b1, 32'h00001000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00001004, 1'b0, 6'h0, 1'b1, 32'haaaa0001, 1'b0, 1'b0);
    step(1'b1, 32'h00001008, 1'b0, 6'h0, 1'b1, 32'haaaa0002, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Exception slot needs no bus data; following slot takes the next return.
    step(1'b1, 32'h00002000, 1'b1, 6'h04, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h00002004, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'h5555aaaa, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with two reads outstanding: next two returns discarded.
    step(1'b1, 32'h00003000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h00003004, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'h11111111, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'h22222222, 1'b0, 1'b1);
    step(1'b1, 32'h80000000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'h33333333, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic, including flushes and returns during flush.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
           6'($urandom), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
    end

    // Reset while two entries are held clears outputs asynchronously.
    step(1'b1, 32'h00004000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00004000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00004004, 1'b0, 6'h0, 1'b1, 32'hcafe0001, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'hcafe0002, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    mq.delete();
    sb.delete();
    disc = 0;
    @(posedge clock);
    #1 reset = 1'b1;

    // Nothing owed after reset: a fresh read gets the first return.
    step(1'b1, 32'h00005000, 1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 6'h0, 1'b1, 32'h0badf00d, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have no parameters; queue depth is fixed at 2 entries.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_valid  input  1  fetch presents a new fetch slot this cycle.
REQ-005 if_pc  input  32  address of the fetch slot.
REQ-006 if_exr_valid  input  1  fetch slot carries a fetch exception; no bus read was issued for it.
REQ-007 if_exr_type  input  6  exception code for the slot.
REQ-008 if_ready  output  1  queue can accept a slot (not full).
REQ-009 ibus_rvalid  input  1  instruction word returned, in request order.
REQ-010 ibus_rdata  input  32  returned instruction word.
REQ-011 flush  input  1  branch/exception redirect; kill all queued and in-flight slots.
REQ-012 id_valid  output  1  head entry complete and presented to decode.
REQ-013 id_ready  input  1  decode accepts head this cycle.
REQ-014 id_pc, id_inst  output  32 each  head address and instruction word.
REQ-015 id_exr_valid, id_exr_type  output  1, 6  head exception flag and code.

Function
REQ-016 Each entry SHALL hold pc, exr_valid, exr_type, data_done and inst; an entry is complete when exr_valid or data_done is set.
REQ-017 Push SHALL occur when if_valid && if_ready && !flush; the pushed entry has data_done=0 and inst=0.
REQ-018 if_ready SHALL be 1 when fewer than 2 entries are held, regardless of a same-cycle pop.
REQ-019 An accepted slot with if_exr_valid=0 SHALL count as one outstanding bus read.
REQ-020 ibus_rvalid with discard count zero SHALL write ibus_rdata into the oldest entry with exr_valid=0 and data_done=0 and set its data_done.
REQ-021 ibus_rvalid with discard count nonzero SHALL decrement the discard count and leave the queue unchanged.
REQ-022 ibus_rvalid with discard count zero and no waiting entry SHALL be ignored.
REQ-023 id_valid, id_pc, id_inst, id_exr_valid and id_exr_type SHALL be driven combinationally from the head entry; id_valid=1 only when the head is complete.
REQ-024 Pop SHALL occur when id_valid && id_ready && !flush.
REQ-025 Minimum latency SHALL be one cycle: data returned in cycle N is presented in cycle N+1; an exception slot pushed in cycle N is presented in cycle N+1.
REQ-026 Same-cycle push and pop SHALL be supported when one entry is held.
REQ-027 On flush, the queue SHALL empty on the next edge.
REQ-028 On flush, the discard count SHALL be set to its current value plus the number of queued entries still awaiting data.
REQ-029 A same-cycle ibus_rvalid during flush SHALL be treated as belonging to the oldest waiting entry, or to a pending discard, and SHALL never be delivered.
REQ-030 The discard count SHALL saturate at 2.
REQ-031 id_valid SHALL be 0 in the cycle after flush.

Reset
REQ-032 While reset=0 the block SHALL clear all entries, pointers and the discard count.
REQ-033 During reset, id_valid=0, if_ready=1, and id_pc, id_inst, id_exr_valid and id_exr_type = 0.
REQ-034 Reset assertion mid-transfer SHALL drop the transfer; no discard bookkeeping SHALL be retained after reset.

Configuration
REQ-035 With IF_ID_BUBBLE_CNT_EN defined, output bubble_cnt [31:0] SHALL exist and increment once per cycle in which id_valid=0 and reset=1.
REQ-036 With IF_ID_BUBBLE_CNT_EN defined, bubble_cnt SHALL wrap at 2^32 and clear on reset.
REQ-037 Without IF_ID_BUBBLE_CNT_EN, neither the port nor the counter logic SHALL exist.

Verification
REQ-038 Push pc=0xbfc00000; rvalid with data 0x24080001 next cycle -> id_valid one cycle later with id_pc=0xbfc00000 and id_inst=0x24080001.
REQ-039 Push two slots with id_ready=0 and both rvalids -> if_ready=0; a third if_valid is not accepted; then id_ready=1 -> both pop in order.
REQ-040 Push a slot with if_exr_valid=1 and exr_type=0x04 -> presented the next cycle with inst=0 and no rvalid consumed; a following normal slot still receives the next rvalid.
REQ-041 Two slots awaiting data, then flush -> queue empty; the next two rvalids (0x11111111, 0x22222222) are discarded; a new push pc=0x80000000 takes the third rvalid.
REQ-042 Reset asserted while two entries are held -> id_valid=0 and if_ready=1 immediately (asynchronously).
REQ-043 With IF_ID_BUBBLE_CNT_EN defined: 5 idle cycles after reset -> bubble_cnt=5.
